// File: rtl/gray_wptr_gen.sv
// Write-side pointer and full-flag generator for an asynchronous FIFO (write clock domain).
// It keeps a binary write counter and a registered Gray copy of it for the read domain. The
// read domain's Gray pointer is synchronised locally and used to derive the full, almost-full,
// fill-level and overflow outputs.
//
// Ports:
//   clk             write-domain clock
//   rst_n           asynchronous active-low reset
//   wr_en           write request from the producer
//   rptr_gray_async Gray-coded read pointer from the read domain (asynchronous)
//   waddr           RAM write address; RAM write enable is wr_en & ~full
//   wptr_gray       registered Gray write pointer for the read-domain synchroniser
//   full            FIFO full; writes are refused while high
//   almost_full     registered level >= AF_THRESH
//   level           registered fill count, 0..2**ADDR_WIDTH
//   overflow        one-cycle pulse per write request made while full
module gray_wptr_gen #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = 2**ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow
);

  localparam int unsigned P = ADDR_WIDTH + 1;

  logic [P-1:0] wbin_q, wbin_d;
  logic [P-1:0] wgray_q, wgray_d;
  logic [P-1:0] sync_q [SYNC_STAGES];
  logic [P-1:0] rq_gray, rq_bin;
  logic [P-1:0] level_q, level_d;
  logic         full_q, full_d;
  logic         af_q, af_d;
  logic         ovf_q, ovf_d;
  logic         push;

  // Push qualification uses the registered full, so a refused write never moves the pointer.
  assign push = wr_en & ~full_q;

  assign rq_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    rq_bin        = '0;
    rq_bin[P-1]   = rq_gray[P-1];
    for (int i = int'(P) - 2; i >= 0; i--) begin
      rq_bin[i] = rq_bin[i+1] ^ rq_gray[i];
    end
  end

  always_comb begin
    wbin_d  = wbin_q + {{(P-1){1'b0}}, push};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_d  = (wgray_d == {~rq_gray[P-1:P-2], rq_gray[P-3:0]});
    level_d = wbin_d - rq_bin;
    af_d    = (32'(level_d) >= AF_THRESH);
    ovf_d   = wr_en & full_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  // Read-pointer synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray_async;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_gray_wptr_gen.sv
// Bench for gray_wptr_gen with ADDR_WIDTH=2 (depth 4, 3-bit pointers), SYNC_STAGES=2 and
// AF_THRESH=3. A count-based model predicts every output on every cycle; directed literal
// expectations pin the model down; a random phase adds invariant checks.
module tb_gray_wptr_gen;

  localparam int AW  = 2;
  localparam int P   = AW + 1;
  localparam int SS  = 2;
  localparam int AFT = 3;
  localparam int MOD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [P-1:0]  rptr_gray_async;
  logic [AW-1:0] waddr;
  logic [P-1:0]  wptr_gray;
  logic          full;
  logic          almost_full;
  logic [P-1:0]  level;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  gray_wptr_gen #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SS),
    .AF_THRESH  (AFT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .rptr_gray_async(rptr_gray_async),
    .waddr          (waddr),
    .wptr_gray      (wptr_gray),
    .full           (full),
    .almost_full    (almost_full),
    .level          (level),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int g_of(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  // Gray to binary: each binary bit is the parity of the Gray bits at or above it.
  function automatic int g2b(input logic [P-1:0] g);
    int b;
    b = 0;
    for (int i = 0; i < P; i++) begin
      if (^(g >> i)) b = b | (1 << i);
    end
    return b;
  endfunction

  function automatic int w_next(input int w, input logic we, input logic f);
    return (w + ((we && !f) ? 1 : 0)) % MOD;
  endfunction

  function automatic int lvl(input int wn, input logic [P-1:0] rg);
    return (wn - g2b(rg) + MOD) % MOD;
  endfunction

  // Model state: number of accepted writes (mod 2**P) and the read-pointer samples in flight.
  int           m_wcnt  = 0;
  int           m_level = 0;
  logic         m_full  = 1'b0;
  logic         m_af    = 1'b0;
  logic         m_ovf   = 1'b0;
  logic [P-1:0] sync_m [SS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wcnt  <= 0;
      m_level <= 0;
      m_full  <= 1'b0;
      m_af    <= 1'b0;
      m_ovf   <= 1'b0;
      for (int i = 0; i < SS; i++) sync_m[i] <= '0;
    end else begin
      m_wcnt  <= w_next(m_wcnt, wr_en, m_full);
      m_level <= lvl(w_next(m_wcnt, wr_en, m_full), sync_m[0]);
      m_full  <= (lvl(w_next(m_wcnt, wr_en, m_full), sync_m[0]) == (1 << AW));
      m_af    <= (lvl(w_next(m_wcnt, wr_en, m_full), sync_m[0]) >= AFT);
      m_ovf   <= wr_en && m_full;
      // sync_m[0] is the oldest sample, i.e. what the DUT sees at the end of its chain.
      for (int i = 0; i < SS - 1; i++) sync_m[i] <= sync_m[i+1];
      sync_m[SS-1] <= rptr_gray_async;
    end
  end

  logic         rnd_en = 1'b0;
  logic [P-1:0] prev_gray = '0;
  logic         prev_full = 1'b0;

  always @(negedge clk) begin
    chk("m_gray", int'(wptr_gray), g_of(m_wcnt));
    chk("m_waddr", int'(waddr), m_wcnt % (1 << AW));
    chk("m_full", int'(full), int'(m_full));
    chk("m_af", int'(almost_full), int'(m_af));
    chk("m_level", int'(level), m_level);
    chk("m_ovf", int'(overflow), int'(m_ovf));
    if (rnd_en) begin
      chk("gray_one_bit_step", int'($countones(wptr_gray ^ prev_gray) <= 1), 1);
      chk("level_max", int'(level <= 3'd4), 1);
      if (overflow) chk("ovf_while_full", int'(prev_full), 1);
    end
    prev_gray <= wptr_gray;
    prev_full <= full;
  end

  int wrap_gray [8] = '{1, 3, 2, 6, 7, 5, 4, 0};
  int r_cnt;

  initial begin
    wr_en           = 1'b0;
    rptr_gray_async = '0;
    rst_n           = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gray", int'(wptr_gray), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_waddr", int'(waddr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill from empty, then push into a full FIFO.
    wr_en = 1'b1;
    chk("fill_waddr0", int'(waddr), 0);
    @(negedge clk);
    chk("fill1_gray", int'(wptr_gray), 3'b001);
    chk("fill1_waddr", int'(waddr), 1);
    chk("fill1_level", int'(level), 1);
    chk("fill1_af", int'(almost_full), 0);
    @(negedge clk);
    chk("fill2_gray", int'(wptr_gray), 3'b011);
    chk("fill2_waddr", int'(waddr), 2);
    @(negedge clk);
    chk("fill3_gray", int'(wptr_gray), 3'b010);
    chk("fill3_waddr", int'(waddr), 3);
    chk("fill3_af", int'(almost_full), 1);
    chk("fill3_full", int'(full), 0);
    @(negedge clk);
    chk("fill4_gray", int'(wptr_gray), 3'b110);
    chk("fill4_full", int'(full), 1);
    chk("fill4_level", int'(level), 4);
    chk("fill4_ovf", int'(overflow), 0);
    @(negedge clk);
    chk("ovf1", int'(overflow), 1);
    chk("ovf1_gray", int'(wptr_gray), 3'b110);
    chk("ovf1_waddr", int'(waddr), 0);
    chk("ovf1_level", int'(level), 4);
    @(negedge clk);
    chk("ovf2", int'(overflow), 1);
    chk("ovf2_gray", int'(wptr_gray), 3'b110);

    // One read: full must lag through the synchroniser.
    wr_en           = 1'b0;
    rptr_gray_async = 3'b001;
    @(negedge clk);
    chk("rd_full_c1", int'(full), 1);
    chk("rd_ovf_off", int'(overflow), 0);
    @(negedge clk);
    chk("rd_full_c2", int'(full), 1);
    @(negedge clk);
    chk("rd_full_c3", int'(full), 0);
    chk("rd_level", int'(level), 3);
    chk("rd_af", int'(almost_full), 1);

    // Reset mid-operation, asserted between clock edges.
    #2 rst_n = 1'b0;
    rptr_gray_async = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    chk("mid_pre_gray", int'(wptr_gray), 3'b011);
    chk("mid_pre_full", int'(full), 0);
    wr_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_gray", int'(wptr_gray), 0);
    chk("mid_level", int'(level), 0);
    chk("mid_waddr", int'(waddr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_first_gray", int'(wptr_gray), 3'b001);
    wr_en = 1'b0;

    // Wrap: the async read pointer leads by the sync latency so the synchronised view trails
    // the write pointer by exactly 2.
    #2 rst_n = 1'b0;
    rptr_gray_async = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_en           = 1'b1;
      rptr_gray_async = P'(g_of(k + 1));
      @(negedge clk);
      chk("wrap_gray", int'(wptr_gray), wrap_gray[k]);
      chk("wrap_full", int'(full), 0);
      chk("wrap_level", int'(level), (k == 0) ? 1 : 2);
    end
    wr_en = 1'b0;

    // Random writes against a modelled reader that never passes the write count.
    #2 rst_n = 1'b0;
    rptr_gray_async = '0;
    @(negedge clk);
    rst_n = 1'b1;
    r_cnt = 0;
    @(negedge clk);
    rnd_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      wr_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && r_cnt != m_wcnt) r_cnt = (r_cnt + 1) % MOD;
      rptr_gray_async = P'(g_of(r_cnt));
      @(negedge clk);
    end
    rnd_en = 1'b0;
    wr_en  = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
